// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-port completion FIFOs drained round-robin onto a
// single registered common data bus, one broadcast per cycle, no bypass.
module writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int PHY_WIDTH  = 6,
  parameter int ROB_WIDTH  = 4,
  parameter int NUM_FU     = 3,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_FU-1:0]                fu_valid,
  output logic [NUM_FU-1:0]                fu_ready,
  input  logic [NUM_FU*ROB_WIDTH-1:0]      fu_rob_idx,
  input  logic [NUM_FU*PHY_WIDTH-1:0]      fu_prd,
  input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_data,
  input  logic [NUM_FU-1:0]                fu_exception,
  input  logic                             flush,
  output logic                             cdb_valid,
  output logic [ROB_WIDTH-1:0]             cdb_rob_idx,
  output logic [PHY_WIDTH-1:0]             cdb_prd,
  output logic [DATA_WIDTH-1:0]            cdb_data,
  output logic                             cdb_exception,
  output logic [1:0]                       cdb_fu_id
);

  localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int ENTRY_W = ROB_WIDTH + PHY_WIDTH + DATA_WIDTH + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
  endfunction

  function automatic logic [1:0] rr_index(input logic [1:0] base, input int offset);
    return 2'((int'(base) + offset) % NUM_FU);
  endfunction

  logic [ENTRY_W-1:0] mem_r      [NUM_FU][BUF_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r   [NUM_FU];
  logic [PTR_W-1:0]   wr_ptr_r   [NUM_FU];
  logic [CNT_W-1:0]   count_r    [NUM_FU];
  logic [1:0]         rr_ptr_r;
  logic [NUM_FU-1:0]  nonempty_s;
  logic [NUM_FU-1:0]  push_s;
  logic [NUM_FU-1:0]  pop_s;
  logic               grant_valid_s;
  logic [1:0]         grant_id_s;
  logic [ENTRY_W-1:0] head_s;
  logic [ENTRY_W-1:0] in_entry_s [NUM_FU];

  // Per-port occupancy flags feeding the arbiter
  always_comb begin
    nonempty_s = {NUM_FU{1'b0}};
    for (int i = 0; i < NUM_FU; i++) begin
      nonempty_s[i] = (count_r[i] != {CNT_W{1'b0}});
    end
  end

  // Round-robin search; scanning from the far end lets the nearest hit win
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 2'd0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      grant_valid_s = grant_valid_s | nonempty_s[rr_index(rr_ptr_r, k)];
      grant_id_s    = nonempty_s[rr_index(rr_ptr_r, k)] ? rr_index(rr_ptr_r, k) : grant_id_s;
    end
    head_s = mem_r[grant_id_s][rd_ptr_r[grant_id_s]];
  end

  // Accept/push/pop per port; ready looks only at state so a full FIFO being drained still accepts
  always_comb begin
    pop_s    = {NUM_FU{1'b0}};
    push_s   = {NUM_FU{1'b0}};
    fu_ready = {NUM_FU{1'b0}};
    for (int i = 0; i < NUM_FU; i++) begin
      pop_s[i]      = grant_valid_s && (grant_id_s == 2'(i));
      fu_ready[i]   = rst || (count_r[i] < CNT_FULL) || pop_s[i];
      push_s[i]     = fu_valid[i] && fu_ready[i] && !flush;
      in_entry_s[i] = {fu_rob_idx[i*ROB_WIDTH +: ROB_WIDTH],
                       fu_prd[i*PHY_WIDTH +: PHY_WIDTH],
                       fu_data[i*DATA_WIDTH +: DATA_WIDTH],
                       fu_exception[i]};
    end
  end

  // Payload storage; stale slots are harmless because pointers/counts gate visibility
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= in_entry_s[i];
      end
    end
  end

  // FIFO bookkeeping, arbitration pointer and registered broadcast
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count_r[i]  <= {CNT_W{1'b0}};
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        wr_ptr_r[i] <= {PTR_W{1'b0}};
      end
      rr_ptr_r      <= 2'd0;
      cdb_valid     <= 1'b0;
      cdb_rob_idx   <= {ROB_WIDTH{1'b0}};
      cdb_prd       <= {PHY_WIDTH{1'b0}};
      cdb_data      <= {DATA_WIDTH{1'b0}};
      cdb_exception <= 1'b0;
      cdb_fu_id     <= 2'd0;
    end else if (flush) begin
      // Flush drops everything in flight but keeps fairness state
      for (int i = 0; i < NUM_FU; i++) begin
        count_r[i]  <= {CNT_W{1'b0}};
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        wr_ptr_r[i] <= {PTR_W{1'b0}};
      end
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= ptr_inc(wr_ptr_r[i]);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= ptr_inc(rd_ptr_r[i]);
        end
        count_r[i] <= count_r[i] + CNT_W'(push_s[i]) - CNT_W'(pop_s[i]);
      end
      cdb_valid <= grant_valid_s;
      if (grant_valid_s) begin
        rr_ptr_r <= rr_index(grant_id_s, 1);
        {cdb_rob_idx, cdb_prd, cdb_data, cdb_exception} <= head_s;
        cdb_fu_id <= grant_id_s;
      end
    end
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, result data width.
REQ-002 SHALL provide parameter PHY_WIDTH, default 6, physical register index width.
REQ-003 SHALL provide parameter ROB_WIDTH, default 4, ROB index width.
REQ-004 SHALL provide parameter NUM_FU, default 3, number of functional-unit completion ports (legal range 2..4).
REQ-005 SHALL provide parameter BUF_DEPTH, default 2, per-port completion FIFO depth (power of two).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 fu_valid  input  NUM_FU  per-port completion valid.
REQ-009 fu_ready  output  NUM_FU  per-port accept; port i handshakes when fu_valid[i] && fu_ready[i] at an edge.
REQ-010 fu_rob_idx  input  NUM_FU*ROB_WIDTH  ROB index of completing op, port i in slice i.
REQ-011 fu_prd  input  NUM_FU*PHY_WIDTH  destination physical register.
REQ-012 fu_data  input  NUM_FU*DATA_WIDTH  result value.
REQ-013 fu_exception  input  NUM_FU  op raised exception.
REQ-014 flush  input  1  pipeline flush (mispredict/exception commit).
REQ-015 cdb_valid  output  1  common data bus broadcast valid, registered.
REQ-016 cdb_rob_idx, cdb_prd, cdb_data, cdb_exception  output  ROB_WIDTH/PHY_WIDTH/DATA_WIDTH/1  broadcast payload, registered.
REQ-017 cdb_fu_id  output  2  port index that sourced the broadcast.

Function
REQ-018 Each port SHALL own a FIFO of BUF_DEPTH entries {rob_idx, prd, data, exception}; entries leave in arrival order.
REQ-019 fu_ready[i] SHALL be high iff FIFO i holds fewer than BUF_DEPTH entries or FIFO i is being popped in the same cycle; combinational from state only, never from fu_valid.
REQ-020 CDB has no backpressure: at most one entry SHALL be popped and broadcast per cycle.
REQ-021 Arbitration SHALL be round-robin: rr_ptr selects highest-priority port; search rr_ptr, rr_ptr+1, ... mod NUM_FU for first non-empty FIFO.
REQ-022 After a grant to port g, rr_ptr SHALL become (g+1) mod NUM_FU; with no grant rr_ptr SHALL hold.
REQ-023 Granted head entry SHALL appear on cdb_* in the cycle after the grant edge; cdb_valid SHALL be low in any cycle following an edge with no grant.
REQ-024 Minimum latency: handshake at edge k -> entry eligible for grant in cycle after edge k -> cdb_valid high after edge k+1.
REQ-025 An entry enqueued at edge k SHALL NOT be granted at edge k (no bypass).
REQ-026 Simultaneous push and pop on a full FIFO SHALL succeed with count unchanged.
REQ-027 FIFO pointers SHALL wrap modulo BUF_DEPTH; count SHALL range 0..BUF_DEPTH.
REQ-028 flush at edge k SHALL empty all FIFOs, drop any handshake at edge k, and force cdb_valid low after edge k; rr_ptr SHALL hold.
REQ-029 cdb payload outputs SHALL hold last value when cdb_valid is low.
REQ-030 fu_exception SHALL pass through unchanged to cdb_exception; no special arbitration.

Reset
REQ-031 rst at an edge SHALL clear all FIFO counts and pointers, set rr_ptr=0, cdb_valid=0, cdb_rob_idx=0, cdb_prd=0, cdb_data=0, cdb_exception=0, cdb_fu_id=0.
REQ-032 During and after reset fu_ready SHALL be all ones; reset mid-operation SHALL discard all buffered entries with no broadcast.
REQ-033 rst SHALL take priority over flush and handshakes in the same cycle.

Verification
REQ-034 Single op: port1 handshake at edge 3 with rob=5, prd=12, data=0xDEAD_BEEF -> cdb_valid=1 after edge 4 only, payload exact, cdb_fu_id=1.
REQ-035 Contention: all three ports push at edge 2, rr_ptr=0 -> broadcasts after edges 3,4,5 from ports 0,1,2; rr_ptr back to 0.
REQ-036 Backpressure: port0 pushes every cycle while ports1,2 also stream -> fu_ready[0] drops after FIFO fills (BUF_DEPTH=2), no entry lost or reordered, each port granted once per 3 cycles.
REQ-037 Flush: fill port0 with 2 entries, assert flush with simultaneous port2 handshake -> cdb_valid low next cycle, no later broadcast of any of the three entries, fu_ready all ones.
REQ-038 Reset mid-stream: rst with 4 entries buffered -> all cdb outputs 0, no subsequent broadcast, rr_ptr=0 verified by next contention order 0,1,2.
REQ-039 Full push+pop: port0 full and granted while pushing -> handshake accepted, count stays 2, FIFO order preserved.
